// File: rtl/draw_player_if.sv
// vga_if: pixel stream bundle shared by the pixel-pipeline stages
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  logic [11:0] rgb;
  modport in (input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// draw_player: overlays a ROM sprite on a vga_if stream; position updates apply at frame boundaries
module draw_player #(
  parameter int WIDTH = 48,
  parameter int HEIGHT = 64,
  parameter int X_INIT = 376,
  parameter int Y_INIT = 268,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter int ADDR_W = 12,
  parameter int HOR_PIXELS = 800,
  parameter int VER_PIXELS = 600
) (
  input logic clk,
  input logic rst,
  vga_if.in vga_in,
  vga_if.out vga_out,
  input logic [11:0] xpos,
  input logic [11:0] ypos,
  input logic pos_valid,
  output logic pos_busy,
  output logic [ADDR_W-1:0] pix_addr,
  input logic [11:0] pix_data
);
  localparam logic [11:0] X_MAX = 12'(HOR_PIXELS - WIDTH);
  localparam logic [11:0] Y_MAX = 12'(VER_PIXELS - HEIGHT);
  localparam logic [11:0] X0 = 12'(X_INIT);
  localparam logic [11:0] Y0 = 12'(Y_INIT);
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
    logic [11:0] rgb;
  } px_t;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_nxt;
  logic [11:0] x_act, y_act, x_pend, y_pend;
  logic [11:0] x_act_nxt, y_act_nxt, x_pend_nxt, y_pend_nxt;
  logic [11:0] hc, vc;
  logic vblnk_prev, frame, hit, hit1, hit2;
  px_t p0, p1, p2, p3;
  assign p0 = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync, vga_in.hblnk, vga_in.vblnk, vga_in.rgb};
  assign hc = {1'b0, vga_in.hcount};
  assign vc = {1'b0, vga_in.vcount};
  assign frame = vga_in.vblnk && !vblnk_prev;
  assign hit = !vga_in.hblnk && !vga_in.vblnk &&
               hc >= x_act && hc <= x_act + 12'(WIDTH - 1) &&
               vc >= y_act && vc <= y_act + 12'(HEIGHT - 1);
  assign pos_busy = state == PENDING;
  // a boundary and a new request in the same cycle: old pending goes live, new one is queued
  always_comb begin
    state_nxt = state;
    x_act_nxt = x_act;
    y_act_nxt = y_act;
    x_pend_nxt = x_pend;
    y_pend_nxt = y_pend;
    if (state == PENDING && frame) begin
      x_act_nxt = x_pend;
      y_act_nxt = y_pend;
      state_nxt = IDLE;
    end
    if (pos_valid) begin
      x_pend_nxt = xpos > X_MAX ? X_MAX : xpos;
      y_pend_nxt = ypos > Y_MAX ? Y_MAX : ypos;
      state_nxt = PENDING;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      x_act <= X0;
      y_act <= Y0;
      x_pend <= X0;
      y_pend <= Y0;
      vblnk_prev <= 1'b0;
      pix_addr <= '0;
      hit1 <= 1'b0;
      hit2 <= 1'b0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      state <= state_nxt;
      x_act <= x_act_nxt;
      y_act <= y_act_nxt;
      x_pend <= x_pend_nxt;
      y_pend <= y_pend_nxt;
      vblnk_prev <= vga_in.vblnk;
      pix_addr <= hit ? ADDR_W'(vc - y_act) * ADDR_W'(WIDTH) + ADDR_W'(hc - x_act) : '0;
      hit1 <= hit;
      hit2 <= hit1;
      p1 <= p0;
      p2 <= p1;
      p3 <= p2;
      p3.rgb <= (hit2 && pix_data != TRANSPARENT) ? pix_data : p2.rgb;
    end
  assign vga_out.hcount = p3.hcount;
  assign vga_out.vcount = p3.vcount;
  assign vga_out.hsync = p3.hsync;
  assign vga_out.vsync = p3.vsync;
  assign vga_out.hblnk = p3.hblnk;
  assign vga_out.vblnk = p3.vblnk;
  assign vga_out.rgb = p3.rgb;
endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: randomized scoreboard bench for draw_player against a pixel-level reference model
module tb_draw_player;
  localparam int W = 48;
  localparam int H = 64;
  localparam int XM = 800 - 48;
  localparam int YM = 600 - 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic pos_valid = 1'b0;
  logic pos_busy;
  logic [11:0] pix_addr;
  logic [11:0] pix_data;
  vga_if vin();
  vga_if vout();
  draw_player dut (
    .clk(clk),
    .rst(rst),
    .vga_in(vin),
    .vga_out(vout),
    .xpos(xpos),
    .ypos(ypos),
    .pos_valid(pos_valid),
    .pos_busy(pos_busy),
    .pix_addr(pix_addr),
    .pix_data(pix_data)
  );
  always #5 clk = ~clk;
  typedef struct {int hc; int vc; int hs; int vs; int hb; int vb; int rgb;} px_t;
  typedef struct {int addr; int busy;} ab_t;
  px_t q[$];
  ab_t qa[$];
  px_t ep;
  ab_t ea;
  int tests = 0;
  int fails = 0;
  int rom_mode = 0;
  int ax = 376, ay = 268, px = 376, py = 268, busy = 0, pvb = 0;
  int r;
  function automatic logic [11:0] rom_f(input int a);
    if (rom_mode == 0) return 12'h0F0;
    if (rom_mode == 1) return a == 0 ? 12'hF0F : 12'h00F;
    return a % 5 == 0 ? 12'hF0F : 12'(a * 37 + 5);
  endfunction
  always @(posedge clk) pix_data <= rom_f(int'(pix_addr));
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // call at a negedge; applies one input pixel, updates the model, returns at the next negedge
  task automatic drive_px(input int hc, input int vc, input int hb, input int vb,
                          input int pv = 0, input int xr = 0, input int yr = 0);
    int rgb = int'($urandom_range(0, 4095));
    int hs = int'($urandom_range(0, 1));
    int vs = int'($urandom_range(0, 1));
    int hit = (!hb && !vb && hc >= ax && hc < ax + W && vc >= ay && vc < ay + H) ? 1 : 0;
    int addr = hit ? (vc - ay) * W + (hc - ax) : 0;
    int rom = int'(rom_f(addr));
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vc);
    vin.hsync = hs[0];
    vin.vsync = vs[0];
    vin.hblnk = hb[0];
    vin.vblnk = vb[0];
    vin.rgb = 12'(rgb);
    pos_valid = pv[0];
    xpos = pv ? 12'(xr) : 12'($urandom);
    ypos = pv ? 12'(yr) : 12'($urandom);
    q.push_back('{hc, vc, hs, vs, hb, vb, (hit && rom != 12'hF0F) ? rom : rgb});
    if (vb && !pvb && busy) begin
      ax = px;
      ay = py;
      busy = 0;
    end
    pvb = vb;
    if (pv) begin
      px = xr > XM ? XM : xr;
      py = yr > YM ? YM : yr;
      busy = 1;
    end
    qa.push_back('{addr, busy});
    @(negedge clk);
  endtask
  task automatic visible(input int n);
    int ex[8] = '{ax, ax + W - 1, ax, ax + W - 1, ax - 1, ax + W, ax, ax};
    int ey[8] = '{ay, ay, ay + H - 1, ay + H - 1, ay, ay, ay - 1, ay + H};
    for (int i = 0; i < 8; i++)
      if (ex[i] >= 0 && ey[i] >= 0) drive_px(ex[i], ey[i], 0, 0);
    for (int i = 0; i < n; i++) begin
      int near = $urandom_range(0, 3) != 0;
      int hc = near ? ax - 3 + int'($urandom_range(0, W + 5)) : int'($urandom_range(0, 799));
      int vc = near ? ay - 2 + int'($urandom_range(0, H + 3)) : int'($urandom_range(0, 599));
      if (hc < 0) hc = 0;
      if (vc < 0) vc = 0;
      drive_px(hc, vc, $urandom_range(0, 7) == 0, 0);
    end
  endtask
  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) drive_px(int'($urandom_range(0, 1055)), 600 + i, int'($urandom_range(0, 1)), 1);
  endtask
  task automatic reset_chk();
    rst = 1'b1;
    #1;
    chk("rst_hcount", int'(vout.hcount), 0);
    chk("rst_vcount", int'(vout.vcount), 0);
    chk("rst_hsync", int'(vout.hsync), 0);
    chk("rst_vsync", int'(vout.vsync), 0);
    chk("rst_hblnk", int'(vout.hblnk), 0);
    chk("rst_vblnk", int'(vout.vblnk), 0);
    chk("rst_rgb", int'(vout.rgb), 0);
    chk("rst_pix_addr", int'(pix_addr), 0);
    chk("rst_pos_busy", int'(pos_busy), 0);
    q.delete();
    qa.delete();
    ax = 376; ay = 268; px = 376; py = 268; busy = 0; pvb = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("pix_addr", int'(pix_addr), ea.addr);
      chk("pos_busy", int'(pos_busy), ea.busy);
    end
    if (q.size() >= 3) begin
      ep = q.pop_front();
      chk("hcount", int'(vout.hcount), ep.hc);
      chk("vcount", int'(vout.vcount), ep.vc);
      chk("hsync", int'(vout.hsync), ep.hs);
      chk("vsync", int'(vout.vsync), ep.vs);
      chk("hblnk", int'(vout.hblnk), ep.hb);
      chk("vblnk", int'(vout.vblnk), ep.vb);
      chk("rgb", int'(vout.rgb), ep.rgb);
    end
  end
  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    @(negedge clk);
    reset_chk();
    rom_mode = 0;
    repeat (2) begin
      visible(250);
      vblank(4);
    end
    rom_mode = 1;
    visible(100);
    drive_px(376, 268, 0, 0);
    drive_px(377, 268, 0, 0);
    vblank(4);
    rom_mode = 2;
    visible(150);
    drive_px(10, 300, 0, 0, 1, 100, 50);
    visible(150);
    vblank(4);
    visible(200);
    vblank(4);
    drive_px(20, 100, 0, 0, 1, 5, 5);
    visible(100);
    drive_px(30, 120, 0, 0, 1, 600, 400);
    visible(100);
    vblank(4);
    visible(200);
    vblank(4);
    drive_px(0, 0, 0, 0, 1, 2000, 2000);
    visible(50);
    vblank(4);
    visible(200);
    drive_px(799, 599, 0, 0);
    drive_px(752, 536, 0, 0);
    vblank(4);
    drive_px(0, 10, 0, 0, 1, 200, 300);
    visible(50);
    drive_px(5, 600, 0, 1, 1, 400, 100);
    vblank(3);
    visible(150);
    vblank(4);
    visible(150);
    vblank(4);
    drive_px(50, 50, 0, 0, 1, 10, 10);
    visible(100);
    reset_chk();
    visible(200);
    vblank(4);
    visible(200);
    vblank(4);
    repeat (20) begin
      r = int'($urandom_range(0, 3));
      visible(100);
      if (r != 0)
        drive_px(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), 0, 0, 1,
                 r == 3 ? 2000 : int'($urandom_range(0, 800)), int'($urandom_range(0, 700)));
      visible(100);
      vblank(3 + int'($urandom_range(0, 3)));
    end
    repeat (6) drive_px(0, 700, 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
